multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 121 ++++++++++++
 tb/tb_multdiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: WIDTH shift-add or restoring shift-subtract
// steps on operand magnitudes, sign applied when the result is registered.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH:0]     mplier, divisor;
  logic [WIDTH-1:0]   rem, quo;
  logic               neg, div_zero;

  logic [WIDTH:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_n, prod;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   rem_n, quo_n, quo_signed, div_res;
  logic               prod_exc, div_exc, start, last;

  always_comb begin
    // WIDTH+1 bits so the most negative operand keeps its magnitude
    mag_a = data_operandA[WIDTH-1] ? ({1'b0, ~data_operandA} + {{WIDTH{1'b0}}, 1'b1})
                                   : {1'b0, data_operandA};
    mag_b = data_operandB[WIDTH-1] ? ({1'b0, ~data_operandB} + {{WIDTH{1'b0}}, 1'b1})
                                   : {1'b0, data_operandB};
    start = ctrl_MULT | ctrl_DIV;
    last  = (count == CW'(WIDTH - 1));

    acc_n    = acc + (mplier[0] ? mcand : '0);
    prod     = neg ? ('0 - acc_n) : acc_n;
    prod_exc = (prod[2*WIDTH-1:WIDTH-1] != '0) && (prod[2*WIDTH-1:WIDTH-1] != '1);

    shifted    = {rem, quo[WIDTH-1]};
    diff       = shifted - divisor;
    rem_n      = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_n      = {quo[WIDTH-2:0], ~diff[WIDTH]};
    quo_signed = neg ? ('0 - quo_n) : quo_n;
    // a positive quotient with the top bit set only arises from MIN / -1
    div_exc    = div_zero | (~neg & quo_n[WIDTH-1]);
    div_res    = div_zero ? '0 : quo_signed;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      divisor        <= '0;
      rem            <= '0;
      quo            <= '0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      state          <= ctrl_MULT ? MULT : DIV;
      count          <= '0;
      acc            <= '0;
      mcand          <= {{(WIDTH-1){1'b0}}, mag_a};
      mplier         <= mag_b;
      divisor        <= mag_b;
      rem            <= '0;
      quo            <= mag_a[WIDTH-1:0];
      neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero       <= (data_operandB == '0);
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        MULT: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= prod[WIDTH-1:0];
            data_exception <= prod_exc;
          end
        end
        DIV: begin
          rem   <= rem_n;
          quo   <= quo_n;
          count <= count + 1'b1;
          if (last) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= div_res;
            data_exception <= div_exc;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed and random operations checked against a
// plain 64-bit arithmetic model of signed multiply and truncating divide.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int errors;
  int checks;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic void model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (!mult && b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      if (mult) p = longint'($signed(a)) * longint'($signed(b));
      else      p = longint'($signed(a)) / longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end
  endfunction

  // Returns at the falling edge just after the start edge (cycle 1).
  task automatic pulse_start(input bit mult, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = mult;
    ctrl_DIV      = !mult;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic monitor(input logic [31:0] exp_res, input logic exp_exc, input string name);
    int busy_cnt = 0;
    int rdy_cnt  = 0;
    int rdy_at   = 0;
    logic [31:0] res_at = 'x;
    logic        exc_at = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (rdy_at == 0) begin
          rdy_at = n;
          res_at = data_result;
          exc_at = data_exception;
        end
      end
      if (n < 40) @(negedge clock);
    end
    checks++; if (rdy_at !== 33) begin errors++; $display("FAIL %s latency: got %0d want 33", name, rdy_at); end
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL %s pulses: got %0d want 1", name, rdy_cnt); end
    checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL %s busy cycles: got %0d want 32", name, busy_cnt); end
    checks++; if (res_at !== exp_res) begin errors++; $display("FAIL %s result: got %h want %h", name, res_at, exp_res); end
    checks++; if (exc_at !== exp_exc) begin errors++; $display("FAIL %s exception: got %b want %b", name, exc_at, exp_exc); end
    checks++; if (data_result !== exp_res || data_exception !== exp_exc) begin
      errors++; $display("FAIL %s hold: got %h/%b want %h/%b", name, data_result, data_exception, exp_res, exp_exc);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s idle busy: got %b want 0", name, busy); end
  endtask

  task automatic do_op(input bit mult, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] r;
    logic        e;
    model(mult, a, b, r, e);
    pulse_start(mult, a, b);
    monitor(r, e, name);
  endtask

  task automatic check_zero(input string name);
    checks++; if (data_result !== 32'd0) begin errors++; $display("FAIL %s result: got %h want 0", name, data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL %s exception: got %b want 0", name, data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL %s rdy: got %b want 0", name, data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    #2;
    check_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    do_op(1'b1, 32'd3, 32'hFFFFFFF9, "mult_3x-7");
    do_op(1'b1, 32'h00010000, 32'h00010000, "mult_ovf");
    do_op(1'b1, 32'h80000000, 32'd1, "mult_min_x1");
    do_op(1'b1, 32'h80000000, 32'h80000000, "mult_min_sq");
    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mult_m1_sq");
  endtask

  task automatic test_div();
    do_op(1'b0, 32'hFFFFFFF9, 32'd2, "div_-7/2");
    do_op(1'b0, 32'd5, 32'd0, "div_by_zero");
    do_op(1'b0, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    do_op(1'b0, 32'h80000000, 32'd2, "div_min/2");
    do_op(1'b0, 32'd7, 32'hFFFFFFF9, "div_7/-7");
    do_op(1'b0, 32'd3, 32'd10, "div_small");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 20)) - 32'd10;
        1: a = 32'($urandom_range(0, 2000)) - 32'd1000;
        2: begin a = a >>> $urandom_range(0, 31); b = b >>> $urandom_range(0, 31); end
        default: ;
      endcase
      do_op(i[0], a, b, i[0] ? "rand_mult" : "rand_div");
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic        e;
    int          early = 0;
    pulse_start(1'b1, 32'd2, 32'd3);
    for (int n = 2; n <= 9; n++) begin
      @(negedge clock);
      if (data_resultRDY) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL abort early pulses: got %0d want 0", early); end
    model(1'b0, 32'd9, 32'd3, r, e);
    pulse_start(1'b0, 32'd9, 32'd3);
    monitor(r, e, "abort_div");
  endtask

  task automatic test_mid_reset();
    do_op(1'b1, 32'd3, 32'd5, "pre_reset");
    pulse_start(1'b1, $urandom, $urandom);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clock);
    @(negedge clock);
    reset         = 1'b0;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd4;
    data_operandB = 32'd5;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    monitor(32'd20, 1'b0, "post_reset_4x5");
  endtask

  initial begin
    clock         = 1'b0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    errors        = 0;
    checks        = 0;
    test_reset();
    test_mult();
    test_div();
    test_abort();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
